// File: rtl/rx_frame_buffer_ctrl.sv
// rtl/rx_frame_buffer_ctrl.sv - Rx byte-event sequencer into a single-frame buffer
module rx_frame_buffer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 16,
  parameter int LEN_W      = $clog2(MAX_BYTES+1),
  parameter int ADDR_W     = $clog2(MAX_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_soc,
  input  logic                  rx_eoc,
  input  logic                  rx_error,
  input  logic                  rx_data_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [2:0]            rx_data_bits,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [LEN_W-1:0]      frm_len,
  output logic [2:0]            frm_last_bits,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frm_dropped,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, HOLD} state_t;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_BYTES);

  state_t                state, state_next;
  logic [LEN_W-1:0]      wp, wp_next, len_next;
  logic [2:0]            last_bits_next;
  logic                  lost, lost_next;
  logic                  drop_next;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem [MAX_BYTES];

  assign frm_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next     = state;
    wp_next        = wp;
    len_next       = frm_len;
    last_bits_next = frm_last_bits;
    lost_next      = lost;
    drop_next      = 1'b0;
    wr_en          = 1'b0;
    case (state)
      IDLE: begin
        if (rx_soc) begin
          state_next = RECV;
          wp_next    = '0;
        end
      end
      RECV: begin
        if (rx_soc) begin
          drop_next = 1'b1;
          wp_next   = '0;
        end else if (rx_eoc) begin
          if (rx_error) begin
            drop_next  = 1'b1;
            state_next = IDLE;
          end else if (rx_data_valid) begin
            // A trailing byte with zero valid bits counts as a full byte.
            if (wp != MAX_CNT) begin
              wr_en      = 1'b1;
              state_next = HOLD;
              if (rx_data_bits == 3'd0) begin
                len_next       = wp + LEN_W'(1);
                last_bits_next = 3'd0;
              end else begin
                len_next       = wp;
                last_bits_next = rx_data_bits;
              end
            end else begin
              drop_next  = 1'b1;
              state_next = IDLE;
            end
          end else if (wp != '0) begin
            len_next       = wp;
            last_bits_next = 3'd0;
            state_next     = HOLD;
          end else begin
            drop_next  = 1'b1;
            state_next = IDLE;
          end
        end else if (rx_error) begin
          state_next = DISCARD;
        end else if (rx_data_valid) begin
          if (wp == MAX_CNT) begin
            state_next = DISCARD;
          end else begin
            wr_en   = 1'b1;
            wp_next = wp + LEN_W'(1);
          end
        end
      end
      DISCARD: begin
        if (rx_soc) begin
          drop_next  = 1'b1;
          wp_next    = '0;
          state_next = RECV;
        end else if (rx_eoc) begin
          drop_next  = 1'b1;
          state_next = IDLE;
        end
      end
      HOLD: begin
        // A frame arriving while one is held is tracked by lost and dropped at its eoc.
        if (lost && rx_eoc) begin
          drop_next = 1'b1;
          lost_next = 1'b0;
        end else if (!lost && rx_soc && !frm_ready) begin
          lost_next = 1'b1;
        end
        if (frm_ready) begin
          lost_next = 1'b0;
          if (lost && !rx_eoc) begin
            state_next = DISCARD;
          end else if (!lost && rx_soc) begin
            wp_next    = '0;
            state_next = RECV;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wp            <= '0;
      frm_len       <= '0;
      frm_last_bits <= 3'd0;
      lost          <= 1'b0;
      frm_dropped   <= 1'b0;
      rd_data       <= '0;
    end else begin
      state         <= state_next;
      wp            <= wp_next;
      frm_len       <= len_next;
      frm_last_bits <= last_bits_next;
      lost          <= lost_next;
      frm_dropped   <= drop_next;
      rd_data       <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wp[ADDR_W-1:0]] <= rx_data;
    end
  end

endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// tb/tb_rx_frame_buffer_ctrl.sv - Directed vector bench for rx_frame_buffer_ctrl
module tb_rx_frame_buffer_ctrl;

  localparam int DW = 8;
  localparam int MB = 16;
  localparam int LW = $clog2(MB+1);
  localparam int AW = $clog2(MB);

  localparam logic [5:0] C0  = 6'b000000;
  localparam logic [5:0] CR  = 6'b100000;
  localparam logic [5:0] CS  = 6'b010000;
  localparam logic [5:0] CE  = 6'b001000;
  localparam logic [5:0] CER = 6'b000100;
  localparam logic [5:0] CD  = 6'b000010;
  localparam logic [5:0] CY  = 6'b000001;

  logic          clk = 1'b0;
  logic          rst, rx_soc, rx_eoc, rx_error, rx_data_valid, frm_ready;
  logic [DW-1:0] rx_data, rd_data;
  logic [2:0]    rx_data_bits, frm_last_bits;
  logic          frm_valid, frm_dropped, busy;
  logic [LW-1:0] frm_len;
  logic [AW-1:0] rd_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_frame_buffer_ctrl #(.DATA_WIDTH(DW), .MAX_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .rx_soc(rx_soc), .rx_eoc(rx_eoc), .rx_error(rx_error),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_data_bits(rx_data_bits),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_len(frm_len),
    .frm_last_bits(frm_last_bits), .rd_addr(rd_addr), .rd_data(rd_data),
    .frm_dropped(frm_dropped), .busy(busy)
  );

  typedef struct {
    logic [5:0] c;
    logic [7:0] d;
    logic [2:0] b;
    int         ra;
    logic [7:0] erd;
    logic       ev, ed, eb;
    int         len, lb;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] c, input logic [7:0] d, input logic [2:0] b,
                     input logic [AW-1:0] a);
    rst = c[5]; rx_soc = c[4]; rx_eoc = c[3]; rx_error = c[2];
    rx_data_valid = c[1]; frm_ready = c[0];
    rx_data = d; rx_data_bits = b; rd_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] c, input logic [7:0] d, input logic [2:0] b,
                     input int ra, input logic [7:0] erd,
                     input logic ev, input logic ed, input logic eb,
                     input int len, input int lb);
    vec_t v;
    v.c = c; v.d = d; v.b = b; v.ra = ra; v.erd = erd;
    v.ev = ev; v.ed = ed; v.eb = eb; v.len = len; v.lb = lb;
    tbl.push_back(v);
  endtask

  task automatic outs(input string n, input logic v, input logic d, input logic b);
    check({n, " valid"}, frm_valid, v);
    check({n, " drop"}, frm_dropped, d);
    check({n, " busy"}, busy, b);
  endtask

  initial begin
    rst = 1'b1; rx_soc = 0; rx_eoc = 0; rx_error = 0; rx_data_valid = 0;
    frm_ready = 0; rx_data = '0; rx_data_bits = '0; rd_addr = '0;

    // reset state
    add(CR, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    add(CR, 0, 0, 3, 8'h00, 0, 0, 0, 0, 0);
    // normal frame, reads, release, ready ignored in IDLE
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h26, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h93, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h20, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 1, 0, 1, 3, 0);
    add(C0, 0, 0, 0, 8'h26, 1, 0, 1, 3, 0);
    add(C0, 0, 0, 1, 8'h93, 1, 0, 1, 3, 0);
    add(C0, 0, 0, 2, 8'h20, 1, 0, 1, 3, 0);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // short frame: single 7-bit byte
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE|CD, 8'h26, 7, -1, 0, 1, 0, 1, 0, 7);
    add(C0, 0, 0, 0, 8'h26, 1, 0, 1, 0, 7);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // final byte with data_bits=0 counts as full; ready ignored in RECV
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD|CY, 8'hAA, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE|CD, 8'h55, 0, -1, 0, 1, 0, 1, 2, 0);
    add(C0, 0, 0, 1, 8'h55, 1, 0, 1, 2, 0);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // eoc+error drops once
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h01, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h02, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE|CER, 0, 0, -1, 0, 0, 1, 0, 0, 0);
    add(C0, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // empty frame
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 0, 1, 0, 0, 0);
    add(C0, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // error mid-frame -> DISCARD until eoc
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h03, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CER, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h04, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 0, 1, 0, 0, 0);
    add(C0, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // soc in RECV restarts with a drop
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h11, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CS, 0, 0, -1, 0, 0, 1, 1, 0, 0);
    add(CD, 8'h22, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 1, 0, 1, 1, 0);
    add(C0, 0, 0, 0, 8'h22, 1, 0, 1, 1, 0);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // back-to-back: ready with soc
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h01, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 1, 0, 1, 1, 0);
    add(CY|CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h02, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h03, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 1, 0, 1, 2, 0);
    add(C0, 0, 0, 0, 8'h02, 1, 0, 1, 2, 0);
    add(C0, 0, 0, 1, 8'h03, 1, 0, 1, 2, 0);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // soc in DISCARD restarts with a drop
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CER, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CS, 0, 0, -1, 0, 0, 1, 1, 0, 0);
    add(CD, 8'h77, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 1, 0, 1, 1, 0);
    add(C0, 0, 0, 0, 8'h77, 1, 0, 1, 1, 0);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    // reset mid-RECV, then a normal frame
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h05, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h06, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CR|CS, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    add(C0, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    add(CS, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CD, 8'h44, 0, -1, 0, 0, 0, 1, 0, 0);
    add(CE, 0, 0, -1, 0, 1, 0, 1, 1, 0);
    add(C0, 0, 0, 0, 8'h44, 1, 0, 1, 1, 0);
    add(CY, 0, 0, -1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].c, tbl[i].d, tbl[i].b, (tbl[i].ra < 0) ? '0 : AW'(tbl[i].ra));
      outs($sformatf("v%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eb);
      if (tbl[i].ev || tbl[i].c[5]) begin
        check($sformatf("v%0d len", i), frm_len, tbl[i].len);
        check($sformatf("v%0d last_bits", i), frm_last_bits, tbl[i].lb);
      end
      if (tbl[i].ra >= 0) check($sformatf("v%0d rd_data", i), rd_data, tbl[i].erd);
    end

    // overflow: 17 bytes into a 16-byte buffer
    cyc(CS, 0, 0, '0);
    for (int i = 0; i < MB; i++) cyc(CD, 8'(8'h30 + i), 0, '0);
    outs("ovf16", 0, 0, 1);
    cyc(CD, 8'hFF, 0, '0);
    outs("ovf17", 0, 0, 1);
    cyc(CE, 0, 0, '0);
    outs("ovf_eoc", 0, 1, 0);
    cyc(C0, 0, 0, '0);
    outs("ovf_after", 0, 0, 0);

    // exactly full buffer is accepted
    cyc(CS, 0, 0, '0);
    for (int i = 0; i < MB; i++) cyc(CD, 8'(8'h30 + i), 0, '0);
    cyc(CE, 0, 0, '0);
    outs("full", 1, 0, 1);
    check("full len", frm_len, MB);
    cyc(C0, 0, 0, AW'(MB - 1));
    check("full rd15", rd_data, 8'h3F);
    cyc(CY, 0, 0, '0);

    // full buffer plus partial byte is dropped
    cyc(CS, 0, 0, '0);
    for (int i = 0; i < MB; i++) cyc(CD, 8'(i), 0, '0);
    cyc(CE|CD, 8'h5A, 3, '0);
    outs("full_part", 0, 1, 0);

    // 15 bytes plus partial byte fits
    cyc(CS, 0, 0, '0);
    for (int i = 0; i < MB - 1; i++) cyc(CD, 8'(i), 0, '0);
    cyc(CE|CD, 8'h5A, 3, '0);
    outs("part15", 1, 0, 1);
    check("part15 len", frm_len, MB - 1);
    check("part15 last_bits", frm_last_bits, 3);
    cyc(C0, 0, 0, AW'(MB - 1));
    check("part15 rd", rd_data, 8'h5A);
    cyc(CY, 0, 0, '0);

    // frame B arrives while A is held
    cyc(CS, 0, 0, '0);
    cyc(CD, 8'hA1, 0, '0);
    cyc(CD, 8'hA2, 0, '0);
    cyc(CE, 0, 0, '0);
    cyc(CS, 0, 0, '0);
    outs("lost_soc", 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(CD, 8'(8'hB0 + i), 0, '0);
    outs("lost_data", 1, 0, 1);
    cyc(CE, 0, 0, '0);
    outs("lost_eoc", 1, 1, 1);
    check("lost_eoc len", frm_len, 2);
    cyc(C0, 0, 0, AW'(0));
    outs("lost_after", 1, 0, 1);
    check("held rd0", rd_data, 8'hA1);
    cyc(C0, 0, 0, AW'(1));
    check("held rd1", rd_data, 8'hA2);
    cyc(CY, 0, 0, '0);
    outs("lost_rel", 0, 0, 0);

    // ready raised mid-B sends the tail to DISCARD
    cyc(CS, 0, 0, '0);
    cyc(CD, 8'hC1, 0, '0);
    cyc(CE, 0, 0, '0);
    cyc(CS, 0, 0, '0);
    cyc(CD, 8'hD0, 0, '0);
    cyc(CY, 0, 0, '0);
    outs("mid_rdy", 0, 0, 1);
    cyc(CD, 8'hD1, 0, '0);
    outs("disc_data", 0, 0, 1);
    cyc(CE, 0, 0, '0);
    outs("disc_eoc", 0, 1, 0);
    cyc(C0, 0, 0, '0);
    outs("disc_after", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
